usbdev_aon_suspend_ctrl: RTL and testbench

//  AON-domain sequencer for the USB always-on wake detector: it sequences

---
 rtl/usbdev_pkg.sv | 20 ++
 rtl/usbdev_aon_suspend_ctrl.sv | 146 ++++++++++++++
 tb/tb_usbdev_aon_suspend_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/usbdev_pkg.sv
// Shared usbdev types for the AON suspend/wake sequencer.
// Holds the FSM state encoding and the latched wake cause layout.
package usbdev_pkg;

    typedef enum logic [2:0] {
        AonIdle    = 3'd0,
        AonSettle  = 3'd1,
        AonArm     = 3'd2,
        AonMonitor = 3'd3,
        AonWake    = 3'd4,
        AonRelease = 3'd5
    } aon_susp_state_e;

    typedef struct packed {
        logic sense_lost;
        logic bus_reset;
        logic bus_not_idle;
    } aon_wake_cause_t;

endpackage

// File: rtl/usbdev_aon_suspend_ctrl.sv
// AON suspend hand-off / wake hand-back sequencer beside the wake detector.
// Optional ARM/RELEASE timeout: define USBDEV_AON_SUSPEND_TIMEOUT_EN.
module usbdev_aon_suspend_ctrl
    import usbdev_pkg::*;
#(
    parameter int unsigned SettleCycles  = 4,
    parameter int unsigned TimeoutCycles = 1023
) (
    input  logic       clk_aon_i,
    input  logic       rst_aon_ni,
    input  logic       suspend_req_aon_i,
    input  logic       wake_ack_aon_i,
    input  logic       wake_detect_active_aon_i,
    input  logic       wake_req_aon_i,
    input  logic       bus_not_idle_aon_i,
    input  logic       bus_reset_aon_i,
    input  logic       sense_lost_aon_i,
    output logic       suspend_req_aon_o,
    output logic       wake_ack_aon_o,
    output logic       wake_req_o,
    output logic [2:0] wake_cause_o,
    output logic       busy_o,
    output logic [2:0] state_o,
    output logic       timeout_o
);

    localparam int unsigned CntMax =
        (SettleCycles > TimeoutCycles) ? SettleCycles : TimeoutCycles;
    localparam int unsigned CntW = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] SettleInit = CntW'(SettleCycles - 1);

    aon_susp_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    aon_wake_cause_t cause_q, cause_d;

`ifdef USBDEV_AON_SUSPEND_TIMEOUT_EN
    localparam logic [CntW-1:0] TmoLast = CntW'(TimeoutCycles - 1);
    logic tmo_q, tmo_d;
`endif

    // Next-state, counter and cause update for the single sequencer FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
`ifdef USBDEV_AON_SUSPEND_TIMEOUT_EN
        tmo_d   = 1'b0;
`endif
        case (state_q)
            AonIdle: begin
                if (suspend_req_aon_i) begin
                    state_d = AonSettle;
                    cnt_d   = SettleInit;
                end
            end
            AonSettle: begin
                if (!suspend_req_aon_i) begin
                    state_d = AonIdle;
                end else if (cnt_q == '0) begin
                    state_d = AonArm;
                    cause_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            AonArm: begin
                if (wake_detect_active_aon_i) begin
                    state_d = AonMonitor;
`ifdef USBDEV_AON_SUSPEND_TIMEOUT_EN
                end else if (cnt_q >= TmoLast) begin
                    state_d = AonIdle;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            AonMonitor: begin
                if (wake_req_aon_i) begin
                    state_d = AonWake;
                    cause_d = '{sense_lost:   sense_lost_aon_i,
                                bus_reset:    bus_reset_aon_i,
                                bus_not_idle: bus_not_idle_aon_i};
                end else if (wake_ack_aon_i) begin
                    state_d = AonRelease;
                    cnt_d   = '0;
                end
            end
            AonWake: begin
                if (wake_ack_aon_i) begin
                    state_d = AonRelease;
                    cnt_d   = '0;
                end
            end
            AonRelease: begin
                if (!wake_detect_active_aon_i) begin
                    state_d = AonIdle;
`ifdef USBDEV_AON_SUSPEND_TIMEOUT_EN
                end else if (cnt_q >= TmoLast) begin
                    state_d = AonIdle;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = AonIdle;
        endcase
    end

    // State, counter and latched cause registers.
    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            state_q <= AonIdle;
            cnt_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

`ifdef USBDEV_AON_SUSPEND_TIMEOUT_EN
    // One-cycle timeout pulse aligned with the return to IDLE.
    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
    assign timeout_o = tmo_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign suspend_req_aon_o = (state_q == AonArm);
    assign wake_ack_aon_o    = (state_q == AonRelease);
    assign wake_req_o        = (state_q == AonWake);
    assign busy_o            = (state_q != AonIdle);
    assign state_o           = state_q;
    assign wake_cause_o      = cause_q;

endmodule

// File: tb/tb_usbdev_aon_suspend_ctrl.sv
// Self-checking bench for usbdev_aon_suspend_ctrl.
// Directed table, corner sequences and random run against a model.
module tb_usbdev_aon_suspend_ctrl;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned TMO    = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sreq = 1'b0, ack = 1'b0, act = 1'b0, wreq = 1'b0;
    logic [2:0] ev = 3'b000;
    logic       sreq_o, ack_o, wreq_o, busy_o, tmo_o;
    logic [2:0] cause_o, state_o;

    int total = 0;
    int bad   = 0;

    usbdev_aon_suspend_ctrl #(
        .SettleCycles (SETTLE),
        .TimeoutCycles(TMO)
    ) dut (
        .clk_aon_i               (clk),
        .rst_aon_ni              (rst_n),
        .suspend_req_aon_i       (sreq),
        .wake_ack_aon_i          (ack),
        .wake_detect_active_aon_i(act),
        .wake_req_aon_i          (wreq),
        .bus_not_idle_aon_i      (ev[0]),
        .bus_reset_aon_i         (ev[1]),
        .sense_lost_aon_i        (ev[2]),
        .suspend_req_aon_o       (sreq_o),
        .wake_ack_aon_o          (ack_o),
        .wake_req_o              (wreq_o),
        .wake_cause_o            (cause_o),
        .busy_o                  (busy_o),
        .state_o                 (state_o),
        .timeout_o               (tmo_o)
    );

    always #5 clk = ~clk;

    // {state, sreq_o, ack_o, wreq_o, busy, cause, timeout}
    function automatic logic [10:0] pack_exp(input int ph, input logic [2:0] c,
                                             input logic t);
        logic [2:0] s;
        s = 3'(ph);
        return {s, ph == 2, ph == 5, ph == 4, ph != 0, c, t};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {state_o, sreq_o, ack_o, wreq_o, busy_o, cause_o, tmo_o};
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] got;
        got = dut_vec();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got st=%0d sreq=%b ack=%b wreq=%b busy=%b cause=%b tmo=%b, want st=%0d sreq=%b ack=%b wreq=%b busy=%b cause=%b tmo=%b",
                     name, got[10:8], got[7], got[6], got[5], got[4], got[3:1], got[0],
                     exp[10:8], exp[7], exp[6], exp[5], exp[4], exp[3:1], exp[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic a, input logic v,
                         input logic w, input logic [2:0] e);
        sreq = s; ack = a; act = v; wreq = w; ev = e;
    endtask

    // Reference model: phase numbers follow the documented state encoding.
    // Settle and timeout are tracked as elapsed-cycle counts.
    int         m_ph;
    int         m_elapsed;
    logic [2:0] m_cause;
    logic       m_tmo;

    task automatic model_reset();
        m_ph = 0; m_elapsed = 0; m_cause = 3'b000; m_tmo = 1'b0;
    endtask

    task automatic model_step();
        int nph;
        nph = m_ph;
        m_tmo = 1'b0;
        if (m_ph == 0) begin
            if (sreq) begin nph = 1; m_elapsed = 0; end
        end else if (m_ph == 1) begin
            if (!sreq) nph = 0;
            else if (m_elapsed + 1 >= int'(SETTLE)) begin
                nph = 2; m_cause = 3'b000; m_elapsed = 0;
            end else m_elapsed++;
        end else if (m_ph == 2 || m_ph == 5) begin
            if ((m_ph == 2) == act) nph = (m_ph == 2) ? 3 : 0;
`ifdef USBDEV_AON_SUSPEND_TIMEOUT_EN
            else if (m_elapsed + 1 >= int'(TMO)) begin nph = 0; m_tmo = 1'b1; end
            else m_elapsed++;
`endif
        end else if (m_ph == 3) begin
            if (wreq) begin nph = 4; m_cause = ev; end
            else if (ack) begin nph = 5; m_elapsed = 0; end
        end else if (m_ph == 4) begin
            if (ack) begin nph = 5; m_elapsed = 0; end
        end
        m_ph = nph;
    endtask

    typedef struct {
        logic       s, a, v, w;
        logic [2:0] e;
        int         ph;
        logic [2:0] c;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic a, input logic v,
                                input logic w, input logic [2:0] e,
                                input int ph, input logic [2:0] c);
        vec_t r;
        r.s = s; r.a = a; r.v = v; r.w = w; r.e = e; r.ph = ph; r.c = c;
        return r;
    endfunction

    vec_t tbl[30];

    initial begin
        tbl[0]  = mk(1, 0, 0, 0, 3'b000, 1, 3'b000);
        tbl[1]  = mk(1, 0, 0, 0, 3'b000, 1, 3'b000);
        tbl[2]  = mk(1, 0, 0, 0, 3'b000, 1, 3'b000);
        tbl[3]  = mk(1, 0, 0, 0, 3'b000, 1, 3'b000);
        tbl[4]  = mk(1, 0, 0, 0, 3'b000, 2, 3'b000);
        tbl[5]  = mk(1, 0, 1, 0, 3'b000, 3, 3'b000);
        tbl[6]  = mk(1, 0, 1, 1, 3'b010, 4, 3'b010);
        tbl[7]  = mk(1, 1, 1, 0, 3'b000, 5, 3'b010);
        tbl[8]  = mk(0, 1, 0, 0, 3'b000, 0, 3'b010);
        tbl[9]  = mk(1, 0, 0, 0, 3'b000, 1, 3'b010);
        tbl[10] = mk(1, 0, 0, 0, 3'b000, 1, 3'b010);
        tbl[11] = mk(0, 0, 0, 0, 3'b000, 0, 3'b010);
        tbl[12] = mk(1, 0, 0, 0, 3'b000, 1, 3'b010);
        tbl[13] = mk(1, 0, 0, 0, 3'b000, 1, 3'b010);
        tbl[14] = mk(1, 0, 0, 0, 3'b000, 1, 3'b010);
        tbl[15] = mk(1, 0, 0, 0, 3'b000, 1, 3'b010);
        tbl[16] = mk(1, 0, 0, 0, 3'b000, 2, 3'b000);
        tbl[17] = mk(1, 0, 1, 0, 3'b000, 3, 3'b000);
        tbl[18] = mk(1, 1, 1, 1, 3'b101, 4, 3'b101);
        tbl[19] = mk(1, 1, 1, 1, 3'b000, 5, 3'b101);
        tbl[20] = mk(0, 0, 0, 0, 3'b000, 0, 3'b101);
        tbl[21] = mk(1, 0, 0, 0, 3'b000, 1, 3'b101);
        tbl[22] = mk(1, 0, 0, 0, 3'b000, 1, 3'b101);
        tbl[23] = mk(1, 0, 0, 0, 3'b000, 1, 3'b101);
        tbl[24] = mk(1, 0, 0, 0, 3'b000, 1, 3'b101);
        tbl[25] = mk(1, 0, 0, 0, 3'b000, 2, 3'b000);
        tbl[26] = mk(1, 0, 1, 0, 3'b000, 3, 3'b000);
        tbl[27] = mk(0, 0, 1, 0, 3'b000, 3, 3'b000);
        tbl[28] = mk(0, 1, 1, 0, 3'b111, 5, 3'b000);
        tbl[29] = mk(0, 0, 0, 0, 3'b000, 0, 3'b000);

        #1;
        check("reset", pack_exp(0, 3'b000, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].s, tbl[i].a, tbl[i].v, tbl[i].w, tbl[i].e);
            tick();
            check($sformatf("row%0d", i), pack_exp(tbl[i].ph, tbl[i].c, 1'b0));
        end

        // Reach WAKE, then reset asynchronously between clock edges.
        drive(1, 0, 0, 0, 3'b000);
        repeat (SETTLE + 1) tick();
        drive(1, 0, 1, 0, 3'b000);
        tick();
        drive(1, 0, 1, 1, 3'b100);
        tick();
        check("to_wake", pack_exp(4, 3'b100, 1'b0));
        drive(0, 0, 0, 0, 3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", pack_exp(0, 3'b000, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;

`ifdef USBDEV_AON_SUSPEND_TIMEOUT_EN
        begin
            int n;
            drive(1, 0, 0, 0, 3'b000);
            repeat (SETTLE + 1) tick();
            check("tmo_arm", pack_exp(2, 3'b000, 1'b0));
            drive(0, 0, 0, 0, 3'b000);
            n = 0;
            while (state_o != 3'd0 && n < 40) begin
                tick();
                n++;
            end
            total++;
            if (n != int'(TMO)) begin
                bad++;
                $display("FAIL tmo_len: got %0d cycles, want %0d", n, TMO);
            end
            check("tmo_pulse", pack_exp(0, 3'b000, 1'b1));
            tick();
            check("tmo_clear", pack_exp(0, 3'b000, 1'b0));
        end
`endif

        // Random run against the reference model.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                  3'($urandom_range(0, 7)));
            model_step();
            tick();
            check($sformatf("rand%0d", i), pack_exp(m_ph, m_cause, m_tmo));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
